// File: rtl/cmd_gather.sv
// cmd_gather: receive-side command front end.
//   UART 8N1 receiver -> byte FIFO (first-word-fall-through) -> command parser
//   that assembles 'R'/'W' framed commands into cmd_packet_t words.
//
// Ports (cmd_gather):
//   clk               sole clock
//   rst               synchronous, active-high reset
//   uart_rx_in        asynchronous serial RX line, idles high
//   baud_tick         one-cycle strobe at each bit boundary
//   baud_half_tick    one-cycle strobe at each bit midpoint
//   cmd_fifo_wr_en    one-cycle write pulse for a completed command
//   cmd_fifo_wr_data  {opcode[7:0], addr[31:0], data[31:0]}, held until next command
//
// Optional feature macro: CMD_GATHER_STOP_CHECK_EN
//   defined   -> a stop bit sampled as 0 drops the byte (framing error)
//   undefined -> the stop bit is not checked

package cmd_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_packet_t;
endpackage

// Byte FIFO: circular buffer, head always visible on rd_data_o.
// Ports: wr_en_i/wr_data_i push, rd_en_i pops, rd_data_o head, valid_o = !empty.
module cmd_gather_byte_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       valid_o
);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                empty, full, do_wr, do_rd;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign valid_o   = !empty;
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign do_rd     = rd_en_i && !empty;
  // A pop in the same cycle frees the slot, so a write while full is still taken.
  assign do_wr     = wr_en_i && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
  end
endmodule

// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | start bit seen, confirm at midpoint
//   RX_DATA  | sampling 8 data bits LSB first
//   RX_STOP  | sample stop bit, then wait for bit boundary
// Parser FSM
//   state    | meaning
//   P_OP     | hunting for 'R' or 'W', other bytes discarded
//   P_ADDR   | collecting 4 address bytes, big-endian
//   P_DATA   | collecting 4 data bytes (writes only)
//   P_EMIT   | pulse cmd_fifo_wr_en, parser does not pop
module cmd_gather
  import cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_in,
  input  logic        baud_tick,
  input  logic        baud_half_tick,
  output logic        cmd_fifo_wr_en,
  output cmd_packet_t cmd_fifo_wr_data
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_OP, P_ADDR, P_DATA, P_EMIT} p_state_e;

  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_seen_q, stop_seen_d;
  logic        data_ready, stop_ok;

  logic        byte_fifo_valid, byte_fifo_rd_en;
  logic [7:0]  byte_fifo_rd_data;

  p_state_e    p_state_q, p_state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, addr_shift, data_shift;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  cmd_packet_t pkt_q, pkt_d;

`ifdef CMD_GATHER_STOP_CHECK_EN
  assign stop_ok = rx_sync_q;
`else
  assign stop_ok = 1'b1;
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop_seen_d = stop_seen_q;
    data_ready  = 1'b0;
    case (rx_state_q)
      RX_IDLE:  if (!rx_sync_q) rx_state_d = RX_START;
      RX_START: if (baud_half_tick) begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA;
          bit_cnt_d  = '0;
        end
      end
      RX_DATA: if (baud_half_tick) begin
        shift_d   = {rx_sync_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_state_d  = RX_STOP;
          stop_seen_d = 1'b0;
        end
      end
      RX_STOP: begin
        // The boundary tick that opens the stop bit must not end the frame;
        // only a tick after the stop midpoint does.
        if (!stop_seen_q) begin
          if (baud_half_tick) begin
            stop_seen_d = 1'b1;
            data_ready  = stop_ok;
          end
        end else if (baud_tick) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx_in;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  cmd_gather_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_byte_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (data_ready),
    .wr_data_i(shift_q),
    .rd_en_i  (byte_fifo_rd_en),
    .rd_data_o(byte_fifo_rd_data),
    .valid_o  (byte_fifo_valid)
  );

  assign addr_shift = {addr_q[23:0], byte_fifo_rd_data};
  assign data_shift = {data_q[23:0], byte_fifo_rd_data};

  always_comb begin
    p_state_d       = p_state_q;
    opcode_d        = opcode_q;
    addr_d          = addr_q;
    data_d          = data_q;
    byte_cnt_d      = byte_cnt_q;
    pkt_d           = pkt_q;
    byte_fifo_rd_en = 1'b0;
    case (p_state_q)
      P_OP: begin
        byte_fifo_rd_en = byte_fifo_valid;
        if (byte_fifo_valid && (byte_fifo_rd_data == 8'h52 || byte_fifo_rd_data == 8'h57)) begin
          opcode_d   = byte_fifo_rd_data;
          data_d     = '0;
          byte_cnt_d = '0;
          p_state_d  = P_ADDR;
        end
      end
      P_ADDR: begin
        byte_fifo_rd_en = byte_fifo_valid;
        if (byte_fifo_valid) begin
          addr_d     = addr_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (opcode_q == 8'h57) p_state_d = P_DATA;
            else begin
              p_state_d = P_EMIT;
              pkt_d     = {opcode_q, addr_shift, 32'h0};
            end
          end
        end
      end
      P_DATA: begin
        byte_fifo_rd_en = byte_fifo_valid;
        if (byte_fifo_valid) begin
          data_d     = data_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            p_state_d = P_EMIT;
            pkt_d     = {opcode_q, addr_q, data_shift};
          end
        end
      end
      P_EMIT:  p_state_d = P_OP;
      default: p_state_d = P_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_q  <= P_OP;
      opcode_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      pkt_q      <= '0;
    end else begin
      p_state_q  <= p_state_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_q      <= pkt_d;
    end
  end

  // The packet register is loaded on the last pop, so it is already stable in EMIT.
  assign cmd_fifo_wr_en   = (p_state_q == P_EMIT);
  assign cmd_fifo_wr_data = pkt_q;
endmodule

// File: tb/tb_cmd_gather.sv
// Testbench for cmd_gather: serial stimulus against a 16-clock bit period,
// packets checked by a scoreboard monitor; the byte FIFO is also exercised
// through a standalone instance to reach the full condition.
module tb_cmd_gather;
  import cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx_in = 1'b1;
  logic        baud_tick = 1'b0;
  logic        baud_half_tick = 1'b0;
  logic        cmd_fifo_wr_en;
  cmd_packet_t cmd_fifo_wr_data;

  logic       f_rst = 1'b1;
  logic       f_wr_en = 1'b0;
  logic       f_rd_en = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic [7:0] f_rd_data;
  logic       f_valid;

  int n_cmp = 0;
  int n_err = 0;
  cmd_packet_t exp_q[$];
  logic [7:0]  fexp_q[$];
  int unsigned bcnt = 0;

  cmd_gather dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rx_in      (uart_rx_in),
    .baud_tick       (baud_tick),
    .baud_half_tick  (baud_half_tick),
    .cmd_fifo_wr_en  (cmd_fifo_wr_en),
    .cmd_fifo_wr_data(cmd_fifo_wr_data)
  );

  cmd_gather_byte_fifo u_sfifo (
    .clk      (clk),
    .rst      (f_rst),
    .wr_en_i  (f_wr_en),
    .wr_data_i(f_wr_data),
    .rd_en_i  (f_rd_en),
    .rd_data_o(f_rd_data),
    .valid_o  (f_valid)
  );

  always #5 clk = ~clk;

  // 16 clocks per bit: boundary at count 0, midpoint at count 8.
  always @(negedge clk) begin
    baud_tick      = (bcnt == 0);
    baud_half_tick = (bcnt == 8);
    bcnt           = (bcnt == 15) ? 0 : bcnt + 1;
  end

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pkt_unexpected: got %h required none", cmd_fifo_wr_data);
      end else begin
        chk("pkt", cmd_fifo_wr_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (f_rd_en && f_valid) begin
      if (fexp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fifo_unexpected_pop: got %h required none", f_rd_data);
      end else begin
        chk("fifo_pop", {64'h0, f_rd_data}, {64'h0, fexp_q.pop_front()});
      end
    end
  end

  task automatic wait_boundary();
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      #1;
      if (baud_tick) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL baud_timeout: got no baud_tick required one within 40 cycles");
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    wait_boundary();
    uart_rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      #1;
      uart_rx_in = b[i];
    end
    repeat (16) @(negedge clk);
    #1;
    uart_rx_in = ~bad_stop;
    repeat (16) @(negedge clk);
    #1;
    uart_rx_in = 1'b1;
  endtask

  // Sends the first n bytes of v, most significant byte first.
  task automatic send_bytes(input logic [71:0] v, input int n);
    for (int k = 0; k < n; k++) send_byte(v[71-8*k -: 8], 1'b0);
  endtask

  task automatic glitch();
    wait_boundary();
    uart_rx_in = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    uart_rx_in = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {71'h0, cmd_fifo_wr_en}, 72'h0);
    chk("rst_wr_data", cmd_fifo_wr_data, 72'h0);
    chk("fifo_rst_empty", {71'h0, f_valid}, 72'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    f_rst = 1'b0;

    // Standalone FIFO: 17 writes, 17th dropped.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      f_wr_en   = 1'b1;
      f_wr_data = 8'(i);
    end
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    @(negedge clk);
    chk("fifo_full", {71'h0, u_sfifo.full}, 72'h1);
    // Simultaneous read and write while full.
    fexp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    f_rd_en   = 1'b1;
    f_wr_en   = 1'b1;
    f_wr_data = 8'hAA;
    @(posedge clk);
    #1;
    f_rd_en = 1'b0;
    f_wr_en = 1'b0;
    @(negedge clk);
    chk("fifo_full_after_rw", {71'h0, u_sfifo.full}, 72'h1);
    for (int i = 1; i < 16; i++) fexp_q.push_back(8'(i));
    fexp_q.push_back(8'hAA);
    @(posedge clk);
    #1;
    f_rd_en = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    f_rd_en = 1'b0;
    @(negedge clk);
    chk("fifo_empty_after_drain", {71'h0, f_valid}, 72'h0);
    fexp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    f_wr_en   = 1'b1;
    f_wr_data = 8'h3C;
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    f_rd_en = 1'b1;
    @(posedge clk);
    #1;
    f_rd_en = 1'b0;

    // Read command.
    exp_q.push_back({8'h52, 32'h00001004, 32'h00000000});
    send_bytes({8'h52, 32'h00001004, 32'h0}, 5);
    // Write command.
    exp_q.push_back({8'h57, 32'hDEADBEEF, 32'h12345678});
    send_bytes({8'h57, 32'hDEADBEEF, 32'h12345678}, 9);
    // Garbage then read.
    exp_q.push_back({8'h52, 32'h00001004, 32'h00000000});
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_bytes({8'h52, 32'h00001004, 32'h0}, 5);
    // Opcode with a bad stop bit, followed by address bytes that are not opcodes.
`ifndef CMD_GATHER_STOP_CHECK_EN
    exp_q.push_back({8'h52, 32'hCAFE0001, 32'h00000000});
`endif
    send_byte(8'h52, 1'b1);
    send_bytes({32'hCAFE0001, 40'h0}, 4);
    // Start-bit glitch, then a read whose address contains opcode values.
    glitch();
    exp_q.push_back({8'h52, 32'h575200FF, 32'h00000000});
    send_bytes({8'h52, 32'h575200FF, 32'h0}, 5);
    repeat (20) @(negedge clk);
    // Reset after three bytes of a write command.
    send_bytes({8'h57, 8'hDE, 8'hAD, 48'h0}, 3);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_wr_en", {71'h0, cmd_fifo_wr_en}, 72'h0);
    chk("midrst_wr_data", cmd_fifo_wr_data, 72'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({8'h52, 32'h12345678, 32'h00000000});
    send_bytes({8'h52, 32'h12345678, 32'h0}, 5);

    repeat (40) @(negedge clk);
    chk("pkt_pending", 72'(exp_q.size()), 72'h0);
    chk("fifo_pending", 72'(fexp_q.size()), 72'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
